// File: rtl/eth_mac_cfg_req_pkg.sv
// Shared Ethernet ring/pipe types, packet constants and the MAC-config FSM state
// encoding used by the MAC-configuration initiator.
package eth_mac_cfg_req_pkg;

  localparam logic [7:0] MACPID        = 8'h4D;
  localparam logic [7:0] rstPacketType = 8'h01;
  localparam logic [7:0] ackPacketType = 8'h02;

  typedef enum logic [2:0] {
    tx_none,
    tx_start_empty,
    tx_start,
    slot_start,
    slot_data
  } eth_tx_stype_type;

  typedef enum logic [1:0] {
    rx_none,
    rx_start,
    rx_data
  } eth_rx_stype_type;

  typedef struct packed {
    logic [7:0]  pid;
    logic [7:0]  ptype;
    logic [15:0] seqnum;
  } eth_header_type;

  typedef struct packed {
    eth_tx_stype_type stype;
    eth_header_type   header;
    logic [31:0]      data;
  } eth_tx_ring_data_type;

  typedef struct packed {
    eth_rx_stype_type stype;
    eth_header_type   header;
    logic [31:0]      data;
  } eth_rx_pipe_data_type;

  typedef enum logic [2:0] {
    cfg_idle,
    cfg_wait_token,
    cfg_wait_append,
    cfg_send,
    cfg_wait_ack
  } mac_cfg_state_type;

  // Sequence numbers travel on the wire with their bytes swapped.
  function automatic logic [15:0] ldsts_big_endian(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

endpackage

// File: rtl/eth_cfg_retry_timer.sv
// Ack timeout timer and retransmit counter for the MAC-configuration initiator.
module eth_cfg_retry_timer
  import eth_mac_cfg_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       timer_clr,
  input  logic       timer_tick,
  input  logic       retry_clr,
  input  logic       retry_inc,
  output logic       expired,
  output logic       exhausted,
  output logic [3:0] retry_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      retry_cnt <= 4'd0;
    end else begin
      if (timer_clr)       timer_q <= '0;
      else if (timer_tick) timer_q <= timer_q + 1'b1;

      if (retry_clr)      retry_cnt <= 4'd0;
      else if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
    end
  end

  assign expired   = (timer_q == TIMER_LAST);
  assign exhausted = (retry_cnt >= 4'(MAX_RETRY));

endmodule

// File: rtl/eth_mac_cfg_req.sv
// MAC-configuration initiator: injects a reset-type packet carrying a MAC onto the
// tx ring, waits for the matching ack on the rx pipe, retransmits on timeout.
module eth_mac_cfg_req
  import eth_mac_cfg_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // cfg_start is a one-cycle request honoured only while cfg_busy is low; each
  // accepted request ends with exactly one cfg_done or cfg_fail pulse.
  input  logic                 cfg_start,
  input  logic [47:0]          cfg_mac,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_fail,
  output logic [3:0]           retry_cnt,
  output logic [15:0]          seqnum,
  input  eth_rx_pipe_data_type rx_pipe_in,
  output eth_rx_pipe_data_type rx_pipe_out,
  input  eth_tx_ring_data_type tx_ring_in,
  output eth_tx_ring_data_type tx_ring_out,
  output mac_cfg_state_type    cfg_state
);

  mac_cfg_state_type    state_q, state_nxt;
  logic [1:0]           word_q, word_nxt;
  logic [47:0]          mac_q;
  logic [15:0]          seqnum_q;
  logic                 capture, done_nxt, fail_nxt, ovr_en;
  logic                 timer_clr, timer_tick, retry_clr, retry_inc;
  logic                 expired, exhausted, ack_match;
  logic [31:0]          send_word;
  eth_header_type       hdr;
  eth_tx_ring_data_type ovr;

  eth_cfg_retry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) u_retry_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .timer_clr (timer_clr),
    .timer_tick(timer_tick),
    .retry_clr (retry_clr),
    .retry_inc (retry_inc),
    .expired   (expired),
    .exhausted (exhausted),
    .retry_cnt (retry_cnt)
  );

  assign hdr = '{pid: MACPID, ptype: rstPacketType, seqnum: ldsts_big_endian(seqnum_q)};

  assign ack_match = (rx_pipe_in.stype == rx_start) &&
                     (rx_pipe_in.header.pid == MACPID) &&
                     (rx_pipe_in.header.ptype == ackPacketType) &&
                     (rx_pipe_in.header.seqnum == ldsts_big_endian(seqnum_q));

  // Frame body; the last word is the trailer, bit0 clear meaning not corrupted.
  always_comb begin
    send_word = 32'h0;
    case (word_q)
      2'd1:    send_word = {mac_q[15:0], 16'h0};
      2'd2:    send_word = mac_q[47:16];
      default: send_word = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt  = state_q;
    word_nxt   = word_q;
    capture    = 1'b0;
    done_nxt   = 1'b0;
    fail_nxt   = 1'b0;
    timer_clr  = 1'b0;
    timer_tick = 1'b0;
    retry_clr  = 1'b0;
    retry_inc  = 1'b0;
    ovr_en     = 1'b0;
    ovr        = '{stype: tx_none, header: '0, data: '0};
    unique case (state_q)
      cfg_idle: begin
        if (cfg_start) begin
          capture   = 1'b1;
          retry_clr = 1'b1;
          state_nxt = cfg_wait_token;
        end
      end
      cfg_wait_token: begin
        if (tx_ring_in.stype == tx_start_empty) begin
          ovr_en     = 1'b1;
          ovr.stype  = tx_start;
          ovr.header = hdr;
          word_nxt   = 2'd0;
          state_nxt  = cfg_send;
        end else if (tx_ring_in.stype == tx_start) begin
          state_nxt = cfg_wait_append;
        end
      end
      cfg_wait_append: begin
        if (tx_ring_in.stype == tx_none) begin
          ovr_en     = 1'b1;
          ovr.stype  = slot_start;
          ovr.header = hdr;
          word_nxt   = 2'd0;
          state_nxt  = cfg_send;
        end
      end
      cfg_send: begin
        ovr_en    = 1'b1;
        ovr.stype = slot_data;
        ovr.data  = send_word;
        word_nxt  = word_q + 2'd1;
        if (word_q == 2'd3) begin
          timer_clr = 1'b1;
          state_nxt = cfg_wait_ack;
        end
      end
      cfg_wait_ack: begin
        // A matching ack wins over a simultaneous timeout.
        if (ack_match) begin
          done_nxt  = 1'b1;
          state_nxt = cfg_idle;
        end else if (expired) begin
          if (!exhausted) begin
            retry_inc = 1'b1;
            state_nxt = cfg_wait_token;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = cfg_idle;
          end
        end else begin
          timer_tick = 1'b1;
        end
      end
      default: state_nxt = cfg_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= cfg_idle;
      word_q      <= 2'd0;
      mac_q       <= 48'h0;
      seqnum_q    <= 16'h0;
      cfg_done    <= 1'b0;
      cfg_fail    <= 1'b0;
      rx_pipe_out <= '{stype: rx_none, header: '0, data: '0};
      tx_ring_out <= '{stype: tx_none, header: '0, data: '0};
    end else begin
      state_q     <= state_nxt;
      word_q      <= word_nxt;
      cfg_done    <= done_nxt;
      cfg_fail    <= fail_nxt;
      rx_pipe_out <= rx_pipe_in;
      tx_ring_out <= ovr_en ? ovr : tx_ring_in;
      if (capture) begin
        mac_q    <= cfg_mac;
        seqnum_q <= seqnum_q + 16'd1;
      end
    end
  end

  assign cfg_busy  = (state_q != cfg_idle);
  assign seqnum    = seqnum_q;
  assign cfg_state = state_q;

endmodule

// File: tb/tb_eth_mac_cfg_req.sv
// Self-checking bench for eth_mac_cfg_req: frame scoreboard on the tx ring,
// cycle-exact rx pass-through check, and directed exchange scenarios.
module tb_eth_mac_cfg_req;
  import eth_mac_cfg_req_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int RETRIES = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 cfg_start = 1'b0;
  logic [47:0]          cfg_mac = 48'h0;
  logic                 cfg_busy, cfg_done, cfg_fail;
  logic [3:0]           retry_cnt;
  logic [15:0]          seqnum;
  eth_rx_pipe_data_type rx_pipe_in, rx_pipe_out;
  eth_tx_ring_data_type tx_ring_in, tx_ring_out;
  mac_cfg_state_type    cfg_state;

  eth_mac_cfg_req #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(RETRIES)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_start  (cfg_start),
    .cfg_mac    (cfg_mac),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_fail   (cfg_fail),
    .retry_cnt  (retry_cnt),
    .seqnum     (seqnum),
    .rx_pipe_in (rx_pipe_in),
    .rx_pipe_out(rx_pipe_out),
    .tx_ring_in (tx_ring_in),
    .tx_ring_out(tx_ring_out),
    .cfg_state  (cfg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [15:0] exp_seq = 16'h0;
  int frames_seen = 0;
  int mon_word    = 0;
  int last_w3_cyc = 0;
  int done_cnt    = 0;
  int fail_cnt    = 0;

  task automatic push_frame(input logic [15:0] seq, input logic [47:0] mac);
    exp_q.push_back({MACPID, rstPacketType, seq[7:0], seq[15:8]});
    exp_q.push_back(32'h0);
    exp_q.push_back({mac[15:0], 16'h0});
    exp_q.push_back(mac[47:16]);
    exp_q.push_back(32'h0);
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    check_eq({tag, "_avail"}, 96'(exp_q.size() != 0), 96'd1);
    if (exp_q.size() != 0) check_eq(tag, 96'(got), 96'(exp_q.pop_front()));
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_word = 0;
    end else if (mon_word == 0) begin
      if ((tx_ring_out.stype == tx_start || tx_ring_out.stype == slot_start) &&
          tx_ring_out.header.pid == MACPID) begin
        sb_pop("tx_hdr", tx_ring_out.header);
        mon_word = 1;
      end
    end else begin
      check_eq("tx_data_stype", 96'(tx_ring_out.stype), 96'(slot_data));
      sb_pop("tx_data", tx_ring_out.data);
      if (mon_word == 4) begin
        frames_seen++;
        last_w3_cyc = cyc;
        mon_word = 0;
      end else begin
        mon_word++;
      end
    end
    if (reset_n && cfg_done) done_cnt++;
    if (reset_n && cfg_fail) fail_cnt++;
  end

  eth_rx_pipe_data_type rx_prev;
  bit rx_prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset_n && rx_prev_valid) check_eq("rx_pass", 96'(rx_pipe_out), 96'(rx_prev));
    rx_prev       = rx_pipe_in;
    rx_prev_valid = reset_n;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tx(input eth_tx_stype_type st, input logic [7:0] pid, input logic [31:0] d);
    tx_ring_in = '{stype: st, header: '{pid: pid, ptype: 8'h00, seqnum: 16'h0}, data: d};
  endtask

  task automatic start_req(input logic [47:0] mac, input bit accepted);
    cfg_start = 1'b1;
    cfg_mac   = mac;
    tick();
    cfg_start = 1'b0;
    cfg_mac   = {16'($urandom_range(0, 65535)), 32'($urandom)};
    if (accepted) begin
      exp_seq = exp_seq + 16'd1;
      push_frame(exp_seq, mac);
    end
  endtask

  task automatic send_ack(input logic [15:0] seq);
    rx_pipe_in = '{stype: rx_start,
                   header: '{pid: MACPID, ptype: ackPacketType, seqnum: {seq[7:0], seq[15:8]}},
                   data: 32'h0};
    tick();
    rx_pipe_in = '{stype: rx_none, header: '0, data: '0};
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_seen < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("wait_frames", 96'(frames_seen), 96'(n));
  endtask

  task automatic offer_token();
    set_tx(tx_start_empty, 8'h00, 32'h0);
    tick();
    set_tx(tx_none, 8'h00, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [47:0] mac;
    int tok_cyc, w3a, w3b, d0, f0, k;

    rx_pipe_in = '{stype: rx_none, header: '0, data: '0};
    set_tx(tx_none, 8'h00, 32'h0);

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx_stype", 96'(tx_ring_out.stype), 96'(tx_none));
    check_eq("rst_rx_stype", 96'(rx_pipe_out.stype), 96'(rx_none));
    check_eq("rst_status", 96'({cfg_busy, cfg_done, cfg_fail, retry_cnt}), 96'd0);
    check_eq("rst_seqnum", 96'(seqnum), 96'd0);
    check_eq("rst_state", 96'(cfg_state), 96'(cfg_idle));
    @(posedge clk); #3;
    reset_n = 1'b1;
    tick();

    // background rx traffic that must pass through untouched
    for (int i = 0; i < 4; i++) begin
      rx_pipe_in = '{stype: (i == 0) ? rx_start : rx_data,
                     header: '{pid: 8'h22, ptype: ackPacketType, seqnum: 16'($urandom)},
                     data: $urandom};
      tick();
    end
    rx_pipe_in = '{stype: rx_none, header: '0, data: '0};

    // 1: basic exchange
    start_req(48'h0011_2233_4455, 1'b1);
    check_eq("t1_state_wait_token", 96'(cfg_state), 96'(cfg_wait_token));
    check_eq("t1_busy", 96'(cfg_busy), 96'd1);
    check_eq("t1_seqnum", 96'(seqnum), 96'd1);
    check_eq("t1_exp_word1", 96'(exp_q[2]), 96'h4455_0000);
    tok_cyc = cyc;
    offer_token();
    wait_frames(1, 20);
    check_eq("t1_token_to_w3", 96'(last_w3_cyc - tok_cyc), 96'd5);
    check_eq("t1_retry", 96'(retry_cnt), 96'd0);
    d0 = done_cnt;
    send_ack(16'd1);
    @(negedge clk);
    check_eq("t1_done", 96'(cfg_done), 96'd1);
    check_eq("t1_busy_low", 96'(cfg_busy), 96'd0);
    tick(3);
    check_eq("t1_done_once", 96'(done_cnt - d0), 96'd1);

    // 2: occupied token, append after busy slots
    mac = {16'($urandom_range(0, 65535)), 32'($urandom)};
    start_req(mac, 1'b1);
    set_tx(tx_start, 8'h11, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_tx(slot_data, 8'h11, 32'hAAAA_0000 + i);
      tick();
      check_eq("t2_busy_pass", 96'(tx_ring_out.data), 96'(32'hAAAA_0000 + i));
    end
    set_tx(tx_none, 8'h00, 32'h0);
    tick();
    check_eq("t2_slot_start", 96'(tx_ring_out.stype), 96'(slot_start));
    wait_frames(2, 20);
    send_ack(exp_seq);
    @(negedge clk);
    check_eq("t2_done", 96'(cfg_done), 96'd1);
    tick();

    // 3: timeout, retransmit with same seqnum, then fail
    mac = {16'($urandom_range(0, 65535)), 32'($urandom)};
    start_req(mac, 1'b1);
    push_frame(exp_seq, mac);
    push_frame(exp_seq, mac);
    set_tx(tx_start_empty, 8'h00, 32'h0);
    f0 = fail_cnt;
    wait_frames(3, 30);
    w3a = last_w3_cyc;
    wait_frames(4, 60);
    w3b = last_w3_cyc;
    check_eq("t3_retry_spacing", 96'(w3b - w3a), 96'(TIMEOUT + 5));
    wait_frames(5, 60);
    w3a = last_w3_cyc;
    k = 0;
    @(negedge clk);
    while (!cfg_fail && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_eq("t3_fail_latency", 96'(cyc - w3a), 96'(TIMEOUT));
    check_eq("t3_retry_cnt", 96'(retry_cnt), 96'(RETRIES));
    @(posedge clk); #1;
    tick(8);
    check_eq("t3_fail_once", 96'(fail_cnt - f0), 96'd1);
    check_eq("t3_busy_low", 96'(cfg_busy), 96'd0);
    check_eq("t3_frames", 96'(frames_seen), 96'd5);
    check_eq("t3_seqnum", 96'(seqnum), 96'd3);

    // 4: stale ack ignored; good ack on the timeout cycle wins
    mac = {16'($urandom_range(0, 65535)), 32'($urandom)};
    start_req(mac, 1'b1);
    wait_frames(6, 20);
    w3a = last_w3_cyc;
    d0 = done_cnt;
    tick(3);
    send_ack(16'(exp_seq - 16'd1));
    k = 0;
    while (cyc < w3a + TIMEOUT - 1 && k < 100) begin
      tick();
      k++;
    end
    check_eq("t4_stale_no_done", 96'(done_cnt - d0), 96'd0);
    send_ack(exp_seq);
    @(negedge clk);
    check_eq("t4_done", 96'(cfg_done), 96'd1);
    check_eq("t4_retry", 96'(retry_cnt), 96'd0);
    @(posedge clk); #1;
    tick(30);
    check_eq("t4_no_retx", 96'(frames_seen), 96'd6);
    set_tx(tx_none, 8'h00, 32'h0);
    d0 = done_cnt;
    send_ack(exp_seq);
    tick(3);
    check_eq("t4_idle_ack_ignored", 96'(done_cnt - d0), 96'd0);

    // 5: start while busy is ignored; seqnum wrap
    mac = {16'($urandom_range(0, 65535)), 32'($urandom)};
    start_req(mac, 1'b1);
    start_req(~mac, 1'b0);
    check_eq("t5_overlap_seq", 96'(seqnum), 96'(exp_seq));
    offer_token();
    wait_frames(7, 20);
    send_ack(exp_seq);
    @(negedge clk);
    check_eq("t5_done", 96'(cfg_done), 96'd1);
    force dut.seqnum_q = 16'hFFFF;
    @(negedge clk);
    release dut.seqnum_q;
    @(posedge clk); #1;
    exp_seq = 16'hFFFF;
    mac = {16'($urandom_range(0, 65535)), 32'($urandom)};
    start_req(mac, 1'b1);
    check_eq("t5_wrap_seq", 96'(seqnum), 96'd0);
    offer_token();
    wait_frames(8, 20);
    send_ack(16'h0000);
    @(negedge clk);
    check_eq("t5_wrap_done", 96'(cfg_done), 96'd1);
    @(posedge clk); #1;

    // 6: async reset in the middle of SEND
    mac = {16'($urandom_range(0, 65535)), 32'($urandom)};
    start_req(mac, 1'b1);
    offer_token();
    k = 0;
    while (mon_word < 3 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq("t6_reached_w1", 96'(mon_word), 96'd3);
    #1 reset_n = 1'b0;
    #1;
    check_eq("t6_tx_none", 96'(tx_ring_out.stype), 96'(tx_none));
    check_eq("t6_status", 96'({cfg_busy, cfg_done, cfg_fail, retry_cnt}), 96'd0);
    check_eq("t6_seqnum", 96'(seqnum), 96'd0);
    exp_q.delete();
    @(posedge clk); #1;
    tick();
    reset_n = 1'b1;
    tick(4);
    check_eq("t6_after_tx", 96'(tx_ring_out.stype), 96'(tx_none));
    check_eq("t6_after_state", 96'(cfg_state), 96'(cfg_idle));
    check_eq("t6_frames", 96'(frames_seen), 96'd8);

    check_eq("sb_empty", 96'(exp_q.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
